// File: rtl/touch_sample_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : touch_sample_sequencer
//  Description : Resistive touch-panel sampling sequencer. Debounces the
//                pen-down line, issues bursts of N_AVG conversion requests to
//                an external ADC engine, averages the returned X/Y samples,
//                and reports results with a sticky level interrupt. Bursts
//                repeat every PERIOD cycles while the pen stays down.
//  Ports       : clock        - sole clock, rising edge
//                reset        - synchronous active-high reset
//                enable       - run enable; low forces IDLE
//                pen_irq_n    - raw asynchronous pen-down, active low
//                conv_start   - one-cycle conversion request
//                conv_done    - one-cycle conversion complete (X/Y valid)
//                conv_x/y     - 12-bit conversion results
//                x_avg/y_avg  - last averaged result, held
//                data_valid   - one-cycle pulse when x_avg/y_avg update
//                pen_down     - debounced pen state
//                irq          - sticky level interrupt
//                irq_ack      - clears irq and timeout_err
//                timeout_err  - sticky conversion-timeout flag
//  Revision    : 1.0 - initial release
// ============================================================================
module touch_sample_sequencer #(
    parameter int N_AVG    = 4,
    parameter int PERIOD   = 50000,
    parameter int DEBOUNCE = 1000,
    parameter int TIMEOUT  = 4096
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        pen_irq_n,
    output logic        conv_start,
    input  logic        conv_done,
    input  logic [11:0] conv_x,
    input  logic [11:0] conv_y,
    output logic [11:0] x_avg,
    output logic [11:0] y_avg,
    output logic        data_valid,
    output logic        pen_down,
    output logic        irq,
    input  logic        irq_ack,
    output logic        timeout_err
);

    localparam int SHIFT = $clog2(N_AVG);
    localparam int ACC_W = 12 + SHIFT;
    localparam int CNT_W = $clog2(N_AVG + 1);
    localparam int DEB_W = $clog2(DEBOUNCE + 1);
    localparam int PER_W = $clog2(PERIOD + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DEBOUNCE = 3'd1,
        S_START    = 3'd2,
        S_WAIT     = 3'd3,
        S_ACCUM    = 3'd4,
        S_GAP      = 3'd5
    } state_t;

    state_t             state_q;
    logic               sync1_q;
    logic               sync2_q;
    logic [DEB_W-1:0]   deb_cnt_q;
    logic [PER_W-1:0]   per_cnt_q;
    logic [TO_W-1:0]    to_cnt_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ACC_W-1:0]   acc_x_q;
    logic [ACC_W-1:0]   acc_y_q;
    logic               conv_start_q;
    logic               data_valid_q;
    logic               pen_down_q;
    logic               irq_q;
    logic               timeout_err_q;
    logic [11:0]        x_avg_q;
    logic [11:0]        y_avg_q;

    logic               pen;

    assign pen = ~sync2_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            deb_cnt_q     <= '0;
            per_cnt_q     <= '0;
            to_cnt_q      <= '0;
            cnt_q         <= '0;
            acc_x_q       <= '0;
            acc_y_q       <= '0;
            conv_start_q  <= 1'b0;
            data_valid_q  <= 1'b0;
            pen_down_q    <= 1'b0;
            irq_q         <= 1'b0;
            timeout_err_q <= 1'b0;
            x_avg_q       <= '0;
            y_avg_q       <= '0;
        end else begin
            sync1_q      <= pen_irq_n;
            sync2_q      <= sync1_q;
            conv_start_q <= 1'b0;
            data_valid_q <= 1'b0;

            // Acknowledge first; any set later in this block overrides it,
            // so a set coincident with irq_ack is not lost.
            if (irq_ack) begin
                irq_q         <= 1'b0;
                timeout_err_q <= 1'b0;
            end

            // Free-running burst-period counter, restarted on each burst's
            // first conv_start and saturating at PERIOD-1.
            if (per_cnt_q != PER_W'(PERIOD - 1)) begin
                per_cnt_q <= per_cnt_q + PER_W'(1);
            end

            if (!enable) begin
                state_q    <= S_IDLE;
                pen_down_q <= 1'b0;
                cnt_q      <= '0;
                acc_x_q    <= '0;
                acc_y_q    <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (pen) begin
                            state_q   <= S_DEBOUNCE;
                            deb_cnt_q <= '0;
                        end
                    end
                    S_DEBOUNCE: begin
                        if (!pen) begin
                            state_q <= S_IDLE;
                        end else if (deb_cnt_q == DEB_W'(DEBOUNCE - 1)) begin
                            state_q      <= S_START;
                            pen_down_q   <= 1'b1;
                            conv_start_q <= 1'b1;
                            per_cnt_q    <= '0;
                        end else begin
                            deb_cnt_q <= deb_cnt_q + DEB_W'(1);
                        end
                    end
                    S_START: begin
                        state_q  <= S_WAIT;
                        to_cnt_q <= '0;
                    end
                    S_WAIT: begin
                        if (conv_done) begin
                            acc_x_q <= acc_x_q + ACC_W'(conv_x);
                            acc_y_q <= acc_y_q + ACC_W'(conv_y);
                            cnt_q   <= cnt_q + CNT_W'(1);
                            state_q <= S_ACCUM;
                        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                            state_q       <= S_IDLE;
                            timeout_err_q <= 1'b1;
                            irq_q         <= 1'b1;
                            pen_down_q    <= 1'b0;
                            cnt_q         <= '0;
                            acc_x_q       <= '0;
                            acc_y_q       <= '0;
                        end else begin
                            to_cnt_q <= to_cnt_q + TO_W'(1);
                        end
                    end
                    S_ACCUM: begin
                        if (!pen) begin
                            state_q    <= S_IDLE;
                            pen_down_q <= 1'b0;
                            cnt_q      <= '0;
                            acc_x_q    <= '0;
                            acc_y_q    <= '0;
                        end else if (cnt_q != CNT_W'(N_AVG)) begin
                            state_q      <= S_START;
                            conv_start_q <= 1'b1;
                        end else begin
                            // Truncating divide by the power-of-two sample count.
                            x_avg_q      <= acc_x_q[SHIFT +: 12];
                            y_avg_q      <= acc_y_q[SHIFT +: 12];
                            data_valid_q <= 1'b1;
                            irq_q        <= 1'b1;
                            cnt_q        <= '0;
                            acc_x_q      <= '0;
                            acc_y_q      <= '0;
                            state_q      <= S_GAP;
                        end
                    end
                    S_GAP: begin
                        if (per_cnt_q == PER_W'(PERIOD - 1)) begin
                            if (pen) begin
                                state_q      <= S_START;
                                conv_start_q <= 1'b1;
                                per_cnt_q    <= '0;
                            end else begin
                                state_q    <= S_IDLE;
                                pen_down_q <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign conv_start  = conv_start_q;
    assign data_valid  = data_valid_q;
    assign pen_down    = pen_down_q;
    assign irq         = irq_q;
    assign timeout_err = timeout_err_q;
    assign x_avg       = x_avg_q;
    assign y_avg       = y_avg_q;

endmodule
`default_nettype wire

// File: tb/tb_touch_sample_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_touch_sample_sequencer
//  Description : Self-checking bench for touch_sample_sequencer. A randomized
//                ADC responder answers conv_start requests; a scoreboard
//                averages the samples it delivered and compares every result.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_touch_sample_sequencer;

    localparam int N_AVG    = 4;
    localparam int PERIOD   = 60;
    localparam int DEBOUNCE = 8;
    localparam int TIMEOUT  = 20;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        pen_irq_n;
    logic        conv_start;
    logic        conv_done;
    logic [11:0] conv_x;
    logic [11:0] conv_y;
    logic [11:0] x_avg;
    logic [11:0] y_avg;
    logic        data_valid;
    logic        pen_down;
    logic        irq;
    logic        irq_ack;
    logic        timeout_err;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int dv_cnt   = 0;
    int cs_cnt   = 0;
    int done_cnt = 0;
    bit withhold = 1'b0;

    int          cs_times[$];
    logic [11:0] pend_x[$];
    logic [11:0] pend_y[$];
    logic [11:0] dir_x[$];
    logic [11:0] dir_y[$];

    touch_sample_sequencer #(
        .N_AVG   (N_AVG),
        .PERIOD  (PERIOD),
        .DEBOUNCE(DEBOUNCE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .pen_irq_n  (pen_irq_n),
        .conv_start (conv_start),
        .conv_done  (conv_done),
        .conv_x     (conv_x),
        .conv_y     (conv_y),
        .x_avg      (x_avg),
        .y_avg      (y_avg),
        .data_valid (data_valid),
        .pen_down   (pen_down),
        .irq        (irq),
        .irq_ack    (irq_ack),
        .timeout_err(timeout_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_dv(input int budget, input string tag);
        int k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (data_valid !== 1'b1 && k < budget);
        check_eq(tag, 32'(data_valid), 32'd1);
    endtask

    task automatic wait_cs(input int budget, input string tag);
        int k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (conv_start !== 1'b1 && k < budget);
        check_eq(tag, 32'(conv_start), 32'd1);
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int k = 0;
        while (done_cnt < target && k < budget) begin
            @(negedge clock);
            k++;
        end
        check_eq(tag, 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic flush_pending();
        pend_x.delete();
        pend_y.delete();
    endtask

    // ADC responder: answers each request after 1..5 cycles with either a
    // directed sample (if queued) or a random one, and logs what it sent.
    initial begin
        int lat;
        conv_done = 1'b0;
        conv_x    = '0;
        conv_y    = '0;
        forever begin
            @(negedge clock);
            if (conv_start === 1'b1 && !withhold && !reset) begin
                lat = $urandom_range(1, 5);
                repeat (lat) @(negedge clock);
                if (dir_x.size() > 0) begin
                    conv_x = dir_x.pop_front();
                    conv_y = dir_y.pop_front();
                end else begin
                    conv_x = 12'($urandom_range(0, 4095));
                    conv_y = 12'($urandom_range(0, 4095));
                end
                conv_done = 1'b1;
                pend_x.push_back(conv_x);
                pend_y.push_back(conv_y);
                done_cnt++;
                @(negedge clock);
                conv_done = 1'b0;
            end
        end
    end

    // Scoreboard: each result must be the truncated mean of the oldest
    // N_AVG samples delivered since the last result or flush.
    initial begin
        int sx;
        int sy;
        forever begin
            @(negedge clock);
            if (conv_start === 1'b1) begin
                cs_times.push_back(cyc);
                cs_cnt++;
            end
            if (data_valid === 1'b1) begin
                dv_cnt++;
                if (pend_x.size() < N_AVG) begin
                    check_eq("dv_samples_available", pend_x.size(), N_AVG);
                end else begin
                    sx = 0;
                    sy = 0;
                    for (int i = 0; i < N_AVG; i++) begin
                        sx += int'(pend_x.pop_front());
                        sy += int'(pend_y.pop_front());
                    end
                    check_eq("x_avg_model", 32'(x_avg), sx / N_AVG);
                    check_eq("y_avg_model", 32'(y_avg), sy / N_AVG);
                end
            end
        end
    end

    initial begin
        int t0;
        int base_dv;
        int base_cs;
        int base_done;
        int d1;
        int d2;
        logic [11:0] x_prev;

        reset     = 1'b1;
        enable    = 1'b0;
        pen_irq_n = 1'b1;
        irq_ack   = 1'b0;
        tick(5);
        check_eq("rst_conv_start", 32'(conv_start), 0);
        check_eq("rst_data_valid", 32'(data_valid), 0);
        check_eq("rst_pen_down", 32'(pen_down), 0);
        check_eq("rst_irq", 32'(irq), 0);
        check_eq("rst_timeout_err", 32'(timeout_err), 0);
        check_eq("rst_x_avg", 32'(x_avg), 0);
        check_eq("rst_y_avg", 32'(y_avg), 0);
        reset  = 1'b0;
        enable = 1'b1;
        tick(3);

        // Directed burst: X=100..400, Y=4095.
        dir_x = '{12'd100, 12'd200, 12'd300, 12'd400};
        dir_y = '{12'd4095, 12'd4095, 12'd4095, 12'd4095};
        base_dv   = dv_cnt;
        t0        = cyc;
        pen_irq_n = 1'b0;
        wait_cs(60, "t1_first_start_seen");
        // Two synchronizer flops, one IDLE decision, then DEBOUNCE cycles.
        check_eq("t1_start_latency", cyc - t0, DEBOUNCE + 3);
        check_eq("t1_pen_down", 32'(pen_down), 1);
        wait_dv(300, "t1_dv_seen");
        check_eq("t1_x_avg", 32'(x_avg), 250);
        check_eq("t1_y_avg", 32'(y_avg), 4095);
        check_eq("t1_irq", 32'(irq), 1);
        pen_irq_n = 1'b0;
        pen_irq_n = 1'b1;
        tick(PERIOD + 20);
        check_eq("t1_single_dv", dv_cnt - base_dv, 1);
        check_eq("t1_pen_up", 32'(pen_down), 0);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        check_eq("t1_irq_acked", 32'(irq), 0);

        // Short glitch: pen low for DEBOUNCE-1 cycles must not start a burst.
        base_cs   = cs_cnt;
        pen_irq_n = 1'b0;
        tick(DEBOUNCE - 1);
        pen_irq_n = 1'b1;
        tick(DEBOUNCE + 10);
        check_eq("t2_no_start", cs_cnt - base_cs, 0);
        check_eq("t2_pen_down", 32'(pen_down), 0);

        // Held pen, three periods, irq_ack held across the first result.
        cs_times.delete();
        base_dv   = dv_cnt;
        irq_ack   = 1'b1;
        pen_irq_n = 1'b0;
        wait_dv(300, "t3_dv1_seen");
        irq_ack = 1'b0;
        check_eq("t3_irq_set_wins", 32'(irq), 1);
        wait_dv(300, "t3_dv2_seen");
        wait_dv(300, "t3_dv3_seen");
        pen_irq_n = 1'b1;
        tick(PERIOD + 20);
        check_eq("t3_dv_count", dv_cnt - base_dv, 3);
        d1 = (cs_times.size() >= 9) ? cs_times[4] - cs_times[0] : -1;
        d2 = (cs_times.size() >= 9) ? cs_times[8] - cs_times[4] : -1;
        check_eq("t3_period_1", d1, PERIOD);
        check_eq("t3_period_2", d2, PERIOD);
        check_eq("t3_start_count", cs_times.size(), 3 * N_AVG);

        // Pen released after the second sample of a burst.
        x_prev    = x_avg;
        base_dv   = dv_cnt;
        base_done = done_cnt;
        pen_irq_n = 1'b0;
        wait_done(base_done + 2, 300, "t4_two_samples");
        pen_irq_n = 1'b1;
        tick(40);
        check_eq("t4_no_dv", dv_cnt - base_dv, 0);
        check_eq("t4_pen_down", 32'(pen_down), 0);
        check_eq("t4_x_held", 32'(x_avg), 32'(x_prev));
        base_cs = cs_cnt;
        tick(20);
        check_eq("t4_idle_no_start", cs_cnt - base_cs, 0);
        flush_pending();

        // Conversion timeout.
        irq_ack = 1'b1;
        tick(1);
        irq_ack   = 1'b0;
        withhold  = 1'b1;
        pen_irq_n = 1'b0;
        wait_cs(60, "t5_start_seen");
        tick(TIMEOUT);
        check_eq("t5_terr_not_yet", 32'(timeout_err), 0);
        tick(1);
        pen_irq_n = 1'b1;
        check_eq("t5_terr_set", 32'(timeout_err), 1);
        check_eq("t5_irq_set", 32'(irq), 1);
        check_eq("t5_pen_down", 32'(pen_down), 0);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        check_eq("t5_terr_acked", 32'(timeout_err), 0);
        check_eq("t5_irq_acked", 32'(irq), 0);
        tick(10);
        withhold = 1'b0;

        // Enable dropped mid-burst.
        base_dv   = dv_cnt;
        base_done = done_cnt;
        pen_irq_n = 1'b0;
        wait_done(base_done + 2, 300, "t6_two_samples");
        enable = 1'b0;
        tick(5);
        check_eq("t6_pen_down", 32'(pen_down), 0);
        pen_irq_n = 1'b1;
        tick(5);
        enable = 1'b1;
        tick(20);
        check_eq("t6_no_dv", dv_cnt - base_dv, 0);
        flush_pending();

        // Reset asserted mid-burst.
        base_dv   = dv_cnt;
        base_done = done_cnt;
        pen_irq_n = 1'b0;
        wait_done(base_done + 2, 300, "t7_two_samples");
        reset = 1'b1;
        tick(3);
        pen_irq_n = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(10);
        check_eq("t7_no_dv", dv_cnt - base_dv, 0);
        check_eq("t7_x_avg", 32'(x_avg), 0);
        check_eq("t7_y_avg", 32'(y_avg), 0);
        check_eq("t7_pen_down", 32'(pen_down), 0);
        flush_pending();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
